// File: rtl/int8_mac_lane_unpacker.sv
// int8_mac_lane_unpacker
// Return path of the multi-lane MAC. Takes one wide NUM_LANES*LANE_WIDTH
// result and retires it as a sequence of single-lane register writebacks.
// Lanes come out in ascending order. Masked-off lanes are skipped without
// spending a cycle on them.
module int8_mac_lane_unpacker #(
  parameter int NUM_LANES  = 16,
  parameter int LANE_WIDTH = 32,
  parameter int HARTID_W   = 1,
  parameter int ID_W       = 4
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic                            in_valid_i,
  output logic                            in_ready_o,
  input  logic [NUM_LANES*LANE_WIDTH-1:0] in_data_i,
  input  logic [NUM_LANES-1:0]            in_mask_i,
  input  logic [4:0]                      in_rd_base_i,
  input  logic [HARTID_W-1:0]             in_hartid_i,
  input  logic [ID_W-1:0]                 in_id_i,
  input  logic                            flush_i,
  output logic                            out_valid_o,
  input  logic                            out_ready_i,
  output logic [LANE_WIDTH-1:0]           out_data_o,
  output logic [4:0]                      out_rd_addr_o,
  output logic                            out_we_o,
  output logic                            out_last_o,
  output logic [HARTID_W-1:0]             out_hartid_o,
  output logic [ID_W-1:0]                 out_id_o,
  output logic                            done_o,
  output logic                            busy_o
);

  localparam int LANE_IDX_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } state_e;

  state_e                          state_reg;
  logic [NUM_LANES*LANE_WIDTH-1:0] data_reg;
  logic [NUM_LANES-1:0]            mask_reg;
  logic [4:0]                      rd_base_reg;
  logic [HARTID_W-1:0]             hartid_reg;
  logic [ID_W-1:0]                 id_reg;
  logic                            done_reg;

  logic [LANE_WIDTH-1:0]           lane_data [NUM_LANES];
  logic [LANE_IDX_W-1:0]           lane_idx;
  logic [NUM_LANES-1:0]            mask_rest;
  logic                            is_last;
  logic [4:0]                      rd_addr;

  // Split the captured vector into per-lane words so the beat mux is a plain index.
  generate
    for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
      assign lane_data[gi] = data_reg[gi*LANE_WIDTH +: LANE_WIDTH];
    end
  endgenerate

  // Find the lowest remaining lane. The loop walks downward so the smallest set index wins.
  always_comb begin
    lane_idx = '0;
    for (int i = NUM_LANES - 1; i >= 0; i--) begin
      if (mask_reg[i]) begin
        lane_idx = LANE_IDX_W'(i);
      end
    end
  end

  // Clearing the lowest set bit gives the mask after the current beat.
  // The beat is the last one when that result is empty.
  assign mask_rest = mask_reg & (mask_reg - NUM_LANES'(1));
  assign is_last   = (mask_rest == '0);

  // The destination register wraps modulo 32 because the sum is 5 bits wide.
  assign rd_addr = rd_base_reg + 5'(lane_idx);

  assign in_ready_o    = (state_reg == IDLE);
  assign busy_o        = (state_reg == DRAIN);
  assign out_valid_o   = (state_reg == DRAIN);
  assign out_data_o    = lane_data[lane_idx];
  assign out_rd_addr_o = rd_addr;
  assign out_we_o      = (state_reg == DRAIN) && (rd_addr != 5'd0);
  assign out_last_o    = (state_reg == DRAIN) && is_last;
  assign out_hartid_o  = hartid_reg;
  assign out_id_o      = id_reg;
  assign done_o        = done_reg;

  // Capture, drain, flush and completion sequencing.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg   <= IDLE;
      data_reg    <= '0;
      mask_reg    <= '0;
      rd_base_reg <= '0;
      hartid_reg  <= '0;
      id_reg      <= '0;
      done_reg    <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (in_valid_i) begin
            data_reg    <= in_data_i;
            mask_reg    <= in_mask_i;
            rd_base_reg <= in_rd_base_i;
            hartid_reg  <= in_hartid_i;
            id_reg      <= in_id_i;
            // An empty vector has nothing to drain. It retires at once.
            if (in_mask_i != '0) begin
              state_reg <= DRAIN;
            end else begin
              done_reg <= 1'b1;
            end
          end
        end
        DRAIN: begin
          if (flush_i) begin
            // A beat accepted in this cycle has already gone out.
            // Everything still pending is dropped without a done pulse.
            state_reg <= IDLE;
            mask_reg  <= '0;
          end else if (out_ready_i) begin
            mask_reg <= mask_rest;
            if (is_last) begin
              state_reg <= IDLE;
              done_reg  <= 1'b1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_int8_mac_lane_unpacker.sv
// Bench for int8_mac_lane_unpacker.
// The directed vector table lists the expected beat count and the first and
// last destination registers for each vector. A per-beat reference model
// builds the expected beat list from the mask and the base register.
// Further sequences cover flush, reset in the middle of a drain, and
// random vectors.
module tb_int8_mac_lane_unpacker;

  localparam int NL = 16;
  localparam int LW = 32;
  localparam int HW = 1;
  localparam int IW = 4;

  logic              clk_i = 1'b0;
  logic              rst_ni = 1'b0;
  logic              in_valid_i = 1'b0;
  logic              in_ready_o;
  logic [NL*LW-1:0]  in_data_i = '0;
  logic [NL-1:0]     in_mask_i = '0;
  logic [4:0]        in_rd_base_i = '0;
  logic [HW-1:0]     in_hartid_i = '0;
  logic [IW-1:0]     in_id_i = '0;
  logic              flush_i = 1'b0;
  logic              out_valid_o;
  logic              out_ready_i = 1'b1;
  logic [LW-1:0]     out_data_o;
  logic [4:0]        out_rd_addr_o;
  logic              out_we_o;
  logic              out_last_o;
  logic [HW-1:0]     out_hartid_o;
  logic [IW-1:0]     out_id_o;
  logic              done_o;
  logic              busy_o;

  always #5 clk_i = ~clk_i;

  int8_mac_lane_unpacker #(
    .NUM_LANES(NL), .LANE_WIDTH(LW), .HARTID_W(HW), .ID_W(IW)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_data_i(in_data_i),
    .in_mask_i(in_mask_i), .in_rd_base_i(in_rd_base_i), .in_hartid_i(in_hartid_i),
    .in_id_i(in_id_i), .flush_i(flush_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_data_o(out_data_o),
    .out_rd_addr_o(out_rd_addr_o), .out_we_o(out_we_o), .out_last_o(out_last_o),
    .out_hartid_o(out_hartid_o), .out_id_o(out_id_o),
    .done_o(done_o), .busy_o(busy_o)
  );

  typedef struct {
    logic [31:0] data;
    logic [4:0]  rd;
    logic        we;
    logic        last;
  } beat_t;

  typedef struct {
    logic [15:0] mask;
    logic [4:0]  base;
    int          mode;        // 0: ready high, 1: 3-cycle stall on beat 2, 2: random ready
    int          exp_beats;
    logic [4:0]  exp_first;
    logic [4:0]  exp_last;
  } vec_t;

  beat_t       exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] lanes [NL];
  int          beats_seen;
  logic [4:0]  first_rd, last_rd;
  logic        held_v;
  logic [31:0] held_data;
  logic [4:0]  held_rd;
  logic        held_last;
  logic [HW-1:0] exp_hart;
  logic [IW-1:0] exp_id;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: one beat per set mask bit, in ascending lane order.
  // The destination is (base + lane) mod 32.
  task automatic load_model(input logic [15:0] mask, input logic [4:0] base);
    int last_k = -1;
    for (int k = 0; k < NL; k++) if (mask[k]) last_k = k;
    for (int k = 0; k < NL; k++) begin
      if (mask[k]) begin
        beat_t b;
        b.data = lanes[k];
        b.rd   = 5'((int'(base) + k) % 32);
        b.we   = (b.rd != 5'd0);
        b.last = (k == last_k);
        exp_q.push_back(b);
      end
    end
  endtask

  // Sample in the middle of the cycle. A beat seen here with ready high is accepted at the next edge.
  task automatic monitor_sample();
    if (out_valid_o) begin
      if (held_v) begin
        chk("hold_data", out_data_o, held_data);
        chk("hold_rd", out_rd_addr_o, held_rd);
        chk("hold_last", out_last_o, held_last);
      end
      if (out_ready_i) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got rd=%0d data=0x%0h, expected no beat", out_rd_addr_o, out_data_o);
        end else begin
          beat_t e = exp_q.pop_front();
          chk("beat_data", out_data_o, e.data);
          chk("beat_rd", out_rd_addr_o, e.rd);
          chk("beat_we", out_we_o, e.we);
          chk("beat_last", out_last_o, e.last);
          chk("beat_hartid", out_hartid_o, exp_hart);
          chk("beat_id", out_id_o, exp_id);
        end
        if (beats_seen == 0) first_rd = out_rd_addr_o;
        last_rd = out_rd_addr_o;
        beats_seen++;
        held_v = 1'b0;
      end else begin
        held_v    = 1'b1;
        held_data = out_data_o;
        held_rd   = out_rd_addr_o;
        held_last = out_last_o;
      end
    end else begin
      held_v = 1'b0;
    end
  endtask

  task automatic tick();
    @(negedge clk_i);
    monitor_sample();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive_vector(input logic [15:0] mask, input logic [4:0] base,
                              input logic [HW-1:0] hart, input logic [IW-1:0] id);
    for (int k = 0; k < NL; k++) in_data_i[k*LW +: LW] = lanes[k];
    in_mask_i    = mask;
    in_rd_base_i = base;
    in_hartid_i  = hart;
    in_id_i      = id;
    in_valid_i   = 1'b1;
    exp_hart     = hart;
    exp_id       = id;
    exp_q.delete();
    load_model(mask, base);
    beats_seen = 0;
    held_v     = 1'b0;
    tick();
    in_valid_i = 1'b0;
  endtask

  task automatic run_vector(input string tag, input vec_t v, input logic [HW-1:0] hart,
                            input logic [IW-1:0] id);
    int stall_left;
    int budget;
    chk($sformatf("%s_in_ready", tag), in_ready_o, 1);
    drive_vector(v.mask, v.base, hart, id);
    if (v.mask == 16'h0) begin
      chk($sformatf("%s_done_empty", tag), done_o, 1);
      chk($sformatf("%s_busy_empty", tag), busy_o, 0);
      chk($sformatf("%s_ready_empty", tag), in_ready_o, 1);
      tick();
      chk($sformatf("%s_done_drop", tag), done_o, 0);
      chk($sformatf("%s_beats", tag), beats_seen, 0);
    end else begin
      chk($sformatf("%s_first_valid", tag), out_valid_o, 1);
      chk($sformatf("%s_busy", tag), busy_o, 1);
      stall_left = (v.mode == 1) ? 3 : 0;
      budget = 200;
      while (busy_o && budget > 0) begin
        if (stall_left > 0 && beats_seen == 1) begin
          out_ready_i = 1'b0;
          stall_left--;
        end else if (v.mode == 2) begin
          out_ready_i = ($urandom_range(0, 9) < 7);
        end else begin
          out_ready_i = 1'b1;
        end
        tick();
        budget--;
      end
      out_ready_i = 1'b1;
      chk($sformatf("%s_timeout", tag), budget > 0, 1);
      chk($sformatf("%s_done", tag), done_o, 1);
      chk($sformatf("%s_ready_after", tag), in_ready_o, 1);
      chk($sformatf("%s_beats", tag), beats_seen, v.exp_beats);
      chk($sformatf("%s_model_empty", tag), exp_q.size(), 0);
      if (v.mode != 2) begin
        chk($sformatf("%s_first_rd", tag), first_rd, v.exp_first);
        chk($sformatf("%s_last_rd", tag), last_rd, v.exp_last);
      end
      tick();
      chk($sformatf("%s_done_drop", tag), done_o, 0);
    end
    $display("vector %s mask=0x%04h base=%0d beats=%0d", tag, v.mask, v.base, beats_seen);
  endtask

  vec_t vecs[8];
  vec_t rv;
  vec_t fv;

  initial begin
    vecs[0] = '{16'hFFFF, 5'd8,  0, 16, 5'd8,  5'd23};
    vecs[1] = '{16'h8005, 5'd4,  0, 3,  5'd4,  5'd19};
    vecs[2] = '{16'h8005, 5'd4,  1, 3,  5'd4,  5'd19};
    vecs[3] = '{16'h000F, 5'd30, 0, 4,  5'd30, 5'd1};
    vecs[4] = '{16'h0000, 5'd5,  0, 0,  5'd0,  5'd0};
    vecs[5] = '{16'h8000, 5'd31, 0, 1,  5'd14, 5'd14};
    vecs[6] = '{16'h0001, 5'd0,  0, 1,  5'd0,  5'd0};
    vecs[7] = '{16'hA5A5, 5'd20, 1, 8,  5'd20, 5'd3};
    for (int k = 0; k < NL; k++) lanes[k] = 32'h100 + k;

    // Reset values
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_in_ready", in_ready_o, 1);
    chk("rst_out_valid", out_valid_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_rd_addr", out_rd_addr_o, 0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;

    // Directed vectors from the table
    for (int i = 0; i < 8; i++) begin
      run_vector($sformatf("v%0d", i), vecs[i], 1'(i), 4'(i + 3));
    end

    // Flush after beat 3 of 16. No done pulse follows, and a new vector is taken at once.
    fv = '{16'hFFFF, 5'd8, 0, 16, 5'd8, 5'd23};
    drive_vector(fv.mask, fv.base, 1'b1, 4'hA);
    for (int n = 0; n < 50 && beats_seen < 3; n++) tick();
    chk("flush_pre_beats", beats_seen, 3);
    out_ready_i = 1'b0;
    flush_i     = 1'b1;
    tick();
    flush_i     = 1'b0;
    out_ready_i = 1'b1;
    chk("flush_busy", busy_o, 0);
    chk("flush_valid", out_valid_o, 0);
    chk("flush_no_done", done_o, 0);
    chk("flush_in_ready", in_ready_o, 1);
    $display("flush after %0d beats, busy=%0b done=%0b", beats_seen, busy_o, done_o);
    exp_q.delete();
    held_v = 1'b0;
    fv = '{16'h0003, 5'd10, 0, 2, 5'd10, 5'd11};
    run_vector("post_flush", fv, 1'b0, 4'h5);

    // Asynchronous reset during a drain
    fv = '{16'hFFFF, 5'd2, 0, 16, 5'd2, 5'd17};
    drive_vector(fv.mask, fv.base, 1'b0, 4'h7);
    tick();
    tick();
    #2;
    rst_ni = 1'b0;
    #1;
    chk("arst_out_valid", out_valid_o, 0);
    chk("arst_in_ready", in_ready_o, 1);
    chk("arst_busy", busy_o, 0);
    chk("arst_done", done_o, 0);
    $display("async reset mid-drain after %0d beats, valid=%0b ready=%0b", beats_seen, out_valid_o, in_ready_o);
    exp_q.delete();
    held_v = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
    chk("arst_still_idle", busy_o, 0);
    fv = '{16'h0110, 5'd1, 0, 2, 5'd5, 5'd9};
    run_vector("post_reset", fv, 1'b1, 4'h2);

    // Random vectors with random backpressure
    for (int r = 0; r < 20; r++) begin
      for (int k = 0; k < NL; k++) lanes[k] = $urandom;
      rv.mask      = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom);
      rv.base      = 5'($urandom);
      rv.mode      = 2;
      rv.exp_beats = $countones(rv.mask);
      rv.exp_first = '0;
      rv.exp_last  = '0;
      run_vector($sformatf("r%0d", r), rv, 1'($urandom), 4'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Absolute time bound so the bench cannot hang.
  initial begin
    #500000;
    $display("FAIL global_timeout: got no completion, expected finish before 500000");
    $fatal(1);
  end

endmodule

// File: doc/int8_mac_lane_unpacker.md
Name: int8_mac_lane_unpacker

Overview:
- Return path for the multi-lane MAC: accepts one wide NUM_LANES*LANE_WIDTH result vector and serializes it into 32-bit register writebacks, one lane per beat.
- Mirror of the lane-accumulating operand loader: that block builds wide operands from many register writes; this block splits a wide result back into many register writes.
- Sits between the multi-lane unit's vector result and the CVXIF result/writeback arbiter.

Parameters:
NUM_LANES, 16, number of lanes in the wide vector (2..32)
LANE_WIDTH, 32, bits per lane; equals the writeback width XLEN
HARTID_W, 1, hart id width
ID_W, 4, instruction id width

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
in_valid_i  in  1  wide result valid
in_ready_o  out  1  block can accept a wide result
in_data_i  in  NUM_LANES*LANE_WIDTH  lane k at bits [(k+1)*LANE_WIDTH-1 : k*LANE_WIDTH]
in_mask_i  in  NUM_LANES  lanes to write back
in_rd_base_i  in  5  destination register for lane 0
in_hartid_i  in  HARTID_W  hart id
in_id_i  in  ID_W  instruction id
flush_i  in  1  abort the current drain
out_valid_o  out  1  writeback beat valid
out_ready_i  in  1  writeback accepted
out_data_o  out  LANE_WIDTH  lane value
out_rd_addr_o  out  5  destination register
out_we_o  out  1  register write enable
out_last_o  out  1  final beat of this vector
out_hartid_o  out  HARTID_W  captured hart id
out_id_o  out  ID_W  captured instruction id
done_o  out  1  single-cycle pulse when the vector is fully retired
busy_o  out  1  block is in DRAIN

Behaviour:
- Reset (async, rst_ni low):
  - state=IDLE; in_ready_o=1; out_valid_o=0; done_o=0; busy_o=0.
  - All captured registers and the remaining-lane mask are 0.
- FSM has two states, IDLE and DRAIN. in_ready_o = (state==IDLE). busy_o = (state==DRAIN).
- Capture rule: on in_valid_i && in_ready_o, register data, mask, rd_base, hartid and id.
  - Nonzero mask: go to DRAIN; the first out_valid_o is asserted the next cycle (1-cycle latency).
  - Zero mask: stay in IDLE; done_o pulses the next cycle; no beats are emitted.
- DRAIN beat selection:
  - The current lane is the lowest set bit of the remaining mask (ascending lane order).
  - out_data_o = captured lane value.
  - out_rd_addr_o = (rd_base + lane index) mod 32. Wrap past x31 is allowed.
  - out_we_o = (out_rd_addr_o != 0). Beats targeting x0 are still emitted with we=0.
  - out_last_o = 1 when exactly one bit remains in the mask.
- Output handshake:
  - Outputs hold stable while out_valid_o && !out_ready_i.
  - On out_valid_o && out_ready_i, clear the current lane bit; the next beat is presented in the following cycle.
  - Back-to-back beats are allowed: one beat per cycle when ready stays high.
- Completion: on acceptance of the last beat, go to IDLE and pulse done_o for exactly 1 cycle.
  - in_ready_o rises in the cycle after the last beat (no same-cycle reuse).
- flush_i:
  - In DRAIN, flush_i forces IDLE next cycle and clears the mask; done_o is not pulsed.
  - A beat that handshakes in the flush cycle counts as delivered.
  - In IDLE, flush_i has no effect and does not block capture.
- Reset mid-DRAIN: immediate return to the reset values; the pending vector is discarded.
- Masked-off lanes consume no cycles.
- Throughput: popcount(mask) beats per vector plus one idle cycle between vectors.

Test Plan:
- Full vector: mask=0xFFFF, lane k=0x100+k, rd_base=8, ready high.
  - 16 consecutive beats with rd 8..23 and data 0x100..0x10F; last on beat 16; done 1 cycle later; in_ready high again.
- Sparse mask: mask=0x8005, rd_base=4.
  - 3 beats on lanes 0, 2, 15 with rd 4, 6, 19; last only on the rd=19 beat.
- Backpressure: out_ready low for 3 cycles on beat 2.
  - Data, rd and last are held stable; no beat is lost or duplicated; the total beat count equals popcount(mask).
- Wrap and x0: rd_base=30, mask=0x000F.
  - rd 30, 31, 0, 1; we_o=0 only on the rd=0 beat.
- Empty mask and flush:
  - mask=0: done pulses 1 cycle after capture with no beats.
  - Flush after beat 3 of 16: busy drops next cycle, no done, and a new vector is accepted immediately.
- Async reset asserted mid-DRAIN: out_valid_o=0, in_ready_o=1 immediately; the vector is dropped.
